button_debounce: RTL

Synchronises and debounces the raw push-button inputs of the FPGA board before they reach the LED driver and the rest of the Hack I/O logic. Each channel passes through a two-flop synchroniser, then a per-channel stability counter. Per channel it produces a clean level, single-cycle press and release strobes, and a toggle bit that flips on every press. The outputs feed the `leds` stage directly: `but_clean` or `but_toggle` drives its `but` input.

---
 rtl/button_debounce.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/button_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : button_debounce
//  Description : Per-channel two-flop synchroniser followed by a stability
//                counter. Produces a debounced level, one-cycle press and
//                release strobes, and a toggle bit that flips on every press.
//  Revision    : 1.0 - initial release
// ============================================================================
module button_debounce #(
    parameter int WIDTH         = 2,
    parameter int STABLE_CYCLES = 50000,
    parameter int ACTIVE_LOW    = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] but_raw,
    output logic [WIDTH-1:0] but_clean,
    output logic [WIDTH-1:0] but_press,
    output logic [WIDTH-1:0] but_release,
    output logic [WIDTH-1:0] but_toggle
);

    // Counter only has to reach STABLE_CYCLES-1, but keep at least one bit
    // so that STABLE_CYCLES=1 still elaborates a legal vector.
    localparam int CNT_W = (STABLE_CYCLES < 2) ? 1 : $clog2(STABLE_CYCLES + 1);

    // Count value at which the pending level is accepted on the next edge.
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    // Per-channel debounce state: STABLE while the synchronised input agrees
    // with the clean level, PENDING while a disagreement is being timed.
    typedef enum logic [0:0] {
        ST_STABLE  = 1'b0,
        ST_PENDING = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // Input conditioning and synchronisation
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] w_in;
    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;

    // Normalise polarity so that everything downstream is active-high.
    assign w_in = (ACTIVE_LOW != 0) ? ~but_raw : but_raw;

    // Two-flop synchroniser; only the second stage is used downstream.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_in;
            r_sync2 <= r_sync1;
        end
    end

    // ------------------------------------------------------------------------
    // Per-channel stability counter and output generation
    // ------------------------------------------------------------------------
    for (genvar i = 0; i < WIDTH; i++) begin : g_chan

        state_t           r_state;
        state_t           w_state_nxt;
        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] w_cnt_nxt;

        logic             r_clean;
        logic             r_press;
        logic             r_release;
        logic             r_toggle;

        logic             w_clean_nxt;
        logic             w_press_nxt;
        logic             w_release_nxt;
        logic             w_toggle_nxt;

        logic             w_differ;
        logic             w_expire;

        // The synchronised input disagrees with the accepted level.
        assign w_differ = r_sync2[i] ^ r_clean;

        // The disagreement has lasted long enough to be accepted this edge.
        assign w_expire = (r_cnt == C_CNT_LAST);

        // Next-state, counter and strobe decode; strobes default low so they
        // last exactly one cycle.
        always_comb begin
            w_state_nxt   = r_state;
            w_cnt_nxt     = r_cnt;
            w_clean_nxt   = r_clean;
            w_press_nxt   = 1'b0;
            w_release_nxt = 1'b0;
            w_toggle_nxt  = r_toggle;

            case (r_state)
                ST_STABLE: begin
                    if (!w_differ) begin
                        w_cnt_nxt = '0;
                    end else if (w_expire) begin
                        // Only reachable directly from STABLE when a single
                        // differing cycle is enough (STABLE_CYCLES=1).
                        w_clean_nxt = r_sync2[i];
                        w_cnt_nxt   = '0;
                        if (r_sync2[i]) begin
                            w_press_nxt  = 1'b1;
                            w_toggle_nxt = ~r_toggle;
                        end else begin
                            w_release_nxt = 1'b1;
                        end
                    end else begin
                        w_cnt_nxt   = r_cnt + 1'b1;
                        w_state_nxt = ST_PENDING;
                    end
                end

                ST_PENDING: begin
                    if (!w_differ) begin
                        // Bounce back before expiry: all progress is lost.
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_STABLE;
                    end else if (w_expire) begin
                        w_clean_nxt = r_sync2[i];
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_STABLE;
                        if (r_sync2[i]) begin
                            w_press_nxt  = 1'b1;
                            w_toggle_nxt = ~r_toggle;
                        end else begin
                            w_release_nxt = 1'b1;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end

                default: begin
                    w_state_nxt = ST_STABLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end

        // State, counter and registered outputs; reset discards any pending
        // count so no strobe can follow the reset edge.
        always_ff @(posedge clk) begin
            if (reset) begin
                r_state   <= ST_STABLE;
                r_cnt     <= '0;
                r_clean   <= 1'b0;
                r_press   <= 1'b0;
                r_release <= 1'b0;
                r_toggle  <= 1'b0;
            end else begin
                r_state   <= w_state_nxt;
                r_cnt     <= w_cnt_nxt;
                r_clean   <= w_clean_nxt;
                r_press   <= w_press_nxt;
                r_release <= w_release_nxt;
                r_toggle  <= w_toggle_nxt;
            end
        end

        assign but_clean[i]   = r_clean;
        assign but_press[i]   = r_press;
        assign but_release[i] = r_release;
        assign but_toggle[i]  = r_toggle;

    end : g_chan

endmodule
`default_nettype wire
